// File: rtl/cmp_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_seq_pkg
//  Description : Shared types and default widths for the min/max sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package cmp_seq_pkg;

    localparam int c_DATA_W_DEFAULT = 4;
    localparam int c_CNT_W_DEFAULT  = 4;

    // Burst sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/cmp_core.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_core
//  Description : Magnitude comparator, a versus b. Compares as two's-complement
//                when CMP_SIGNED_EN is defined, unsigned otherwise.
//  Revision    : 1.0  initial release
// ============================================================================
module cmp_core #(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_gt,
    output logic              o_lt,
    output logic              o_eq
);

`ifdef CMP_SIGNED_EN
    assign o_gt = $signed(i_a) > $signed(i_b);
    assign o_lt = $signed(i_a) < $signed(i_b);
`else
    assign o_gt = i_a > i_b;
    assign o_lt = i_a < i_b;
`endif
    assign o_eq = (i_a == i_b);

endmodule
`default_nettype wire

// File: rtl/cmp_minmax_seq.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_minmax_seq
//  Description : Accepts a burst of len samples on a valid/ready stream and
//                reports the maximum and minimum sample with their first
//                (0-based) index. Compare signedness set by CMP_SIGNED_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module cmp_minmax_seq
    import cmp_seq_pkg::*;
#(
    parameter int DATA_W = c_DATA_W_DEFAULT,
    parameter int CNT_W  = c_CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] max_out,
    output logic [DATA_W-1:0] min_out,
    output logic [CNT_W-1:0]  max_idx,
    output logic [CNT_W-1:0]  min_idx
);

    state_e             r_state;
    logic [CNT_W-1:0]   r_len;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_max;
    logic [DATA_W-1:0]  r_min;
    logic [CNT_W-1:0]   r_max_idx;
    logic [CNT_W-1:0]   r_min_idx;
    logic               r_busy;
    logic               r_done;

    logic               w_xfer;
    logic               w_last;
    logic               w_max_gt;
    logic               w_max_lt;
    logic               w_max_eq;
    logic               w_min_gt;
    logic               w_min_lt;
    logic               w_min_eq;
    logic               w_unused_cmp;

    // Incoming sample against the running maximum
    cmp_core #(.DATA_W(DATA_W)) u_cmp_max (
        .i_a  (in_data),
        .i_b  (r_max),
        .o_gt (w_max_gt),
        .o_lt (w_max_lt),
        .o_eq (w_max_eq)
    );

    // Incoming sample against the running minimum
    cmp_core #(.DATA_W(DATA_W)) u_cmp_min (
        .i_a  (in_data),
        .i_b  (r_min),
        .o_gt (w_min_gt),
        .o_lt (w_min_lt),
        .o_eq (w_min_eq)
    );

    // Strict compares keep the earliest index on ties, so equality is not needed
    assign w_unused_cmp = ^{w_max_lt, w_max_eq, w_min_gt, w_min_eq};

    assign in_ready = (r_state == RUN);
    assign w_xfer   = in_valid & in_ready;
    assign w_last   = (r_cnt == (r_len - CNT_W'(1)));

    // Burst sequencer and running extreme tracking
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_len     <= '0;
            r_cnt     <= '0;
            r_max     <= '0;
            r_min     <= '0;
            r_max_idx <= '0;
            r_min_idx <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start && (len != '0)) begin
                        r_len   <= len;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_xfer) begin
                        if (r_cnt == '0) begin
                            // First sample seeds both extremes; old results are dropped here
                            r_max     <= in_data;
                            r_min     <= in_data;
                            r_max_idx <= '0;
                            r_min_idx <= '0;
                        end else begin
                            if (w_max_gt) begin
                                r_max     <= in_data;
                                r_max_idx <= r_cnt;
                            end
                            if (w_min_lt) begin
                                r_min     <= in_data;
                                r_min_idx <= r_cnt;
                            end
                        end
                        if (w_last) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign max_out = r_max;
    assign min_out = r_min;
    assign max_idx = r_max_idx;
    assign min_idx = r_min_idx;

endmodule
`default_nettype wire

// File: tb/tb_cmp_minmax_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmp_minmax_seq
//  Description : Self-checking bench for cmp_minmax_seq. Expected extremes are
//                queued when a burst is issued and popped when done pulses.
//                Compare signedness follows CMP_SIGNED_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cmp_minmax_seq;
    import cmp_seq_pkg::*;

    localparam int DW = 4;
    localparam int CW = 4;

    logic          clk      = 1'b0;
    logic          reset_n  = 1'b0;
    logic          start    = 1'b0;
    logic [CW-1:0] len      = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic          in_ready;
    logic          busy;
    logic          done;
    logic [DW-1:0] max_out;
    logic [DW-1:0] min_out;
    logic [CW-1:0] max_idx;
    logic [CW-1:0] min_idx;

    cmp_minmax_seq #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .busy     (busy),
        .done     (done),
        .max_out  (max_out),
        .min_out  (min_out),
        .max_idx  (max_idx),
        .min_idx  (min_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mx;
        int mn;
        int mxi;
        int mni;
    } exp_t;

    int            errors = 0;
    int            checks = 0;
    exp_t          sbq[$];
    exp_t          last_exp;
    logic [DW-1:0] bq[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Numeric value of a sample under the configured interpretation
    function automatic int sval(input logic [DW-1:0] x);
`ifdef CMP_SIGNED_EN
        return int'($signed(x));
`else
        return int'(x);
`endif
    endfunction

    // Reference: extreme values first, then the first position holding each
    function automatic exp_t model();
        exp_t e;
        int   hi;
        int   lo;
        hi = sval(bq[0]);
        lo = hi;
        foreach (bq[i]) begin
            if (sval(bq[i]) > hi) hi = sval(bq[i]);
            if (sval(bq[i]) < lo) lo = sval(bq[i]);
        end
        e.mxi = -1;
        e.mni = -1;
        foreach (bq[i]) begin
            if (e.mxi < 0 && sval(bq[i]) == hi) e.mxi = i;
            if (e.mni < 0 && sval(bq[i]) == lo) e.mni = i;
        end
        e.mx = int'(bq[e.mxi]);
        e.mn = int'(bq[e.mni]);
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding burst
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && done) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 required done=0 (t=%0t)", $time);
            end else begin
                e = sbq.pop_front();
                chk("max_out", int'(max_out), e.mx);
                chk("min_out", int'(min_out), e.mn);
                chk("max_idx", int'(max_idx), e.mxi);
                chk("min_idx", int'(min_idx), e.mni);
            end
        end
    end

    task automatic check_cleared(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 0);
        chk({tag, "_busy"},     int'(busy),     0);
        chk({tag, "_done"},     int'(done),     0);
        chk({tag, "_max_out"},  int'(max_out),  0);
        chk({tag, "_min_out"},  int'(min_out),  0);
        chk({tag, "_max_idx"},  int'(max_idx),  0);
        chk({tag, "_min_idx"},  int'(min_idx),  0);
    endtask

    // Issue one burst from bq; called and returns on a falling edge
    task automatic run_burst(input int gap, input bit poke);
        int   n;
        int   idx;
        int   w;
        int   guard;
        exp_t e;
        n     = bq.size();
        idx   = 0;
        w     = 0;
        guard = 0;
        if (n > 0) begin
            e = model();
            sbq.push_back(e);
            last_exp = e;
        end
        start = 1'b1;
        len   = CW'(n);
        @(negedge clk);
        start = 1'b0;
        if (n == 0) begin
            repeat (3) begin
                chk("len0_busy",     int'(busy),     0);
                chk("len0_in_ready", int'(in_ready), 0);
                @(negedge clk);
            end
            return;
        end
        chk("busy_run", int'(busy), 1);
        while (idx < n && guard < 200) begin
            guard++;
            if (w < gap) begin
                w++;
                in_valid = 1'b0;
                in_data  = DW'($urandom);
                start    = poke;
                len      = CW'($urandom);
            end else begin
                start    = 1'b0;
                in_valid = 1'b1;
                in_data  = bq[idx];
                if (in_ready) begin
                    idx++;
                    w = 0;
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("burst_accepted", idx, n);
        chk("done_latency",  int'(done),     1);
        chk("busy_in_done",  int'(busy),     0);
        chk("ready_in_done", int'(in_ready), 0);
        if (poke) begin
            // start and data offered while in DONE must be ignored
            start    = 1'b1;
            len      = CW'(3);
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            @(negedge clk);
            start    = 1'b0;
            in_valid = 1'b0;
        end
        #1;
        for (int k = 0; k < 10 && sbq.size() != 0; k++) begin
            @(negedge clk);
            #1;
        end
        chk("scoreboard_drained", sbq.size(), 0);
        repeat (2) @(negedge clk);
        chk("hold_max_out", int'(max_out), last_exp.mx);
        chk("hold_min_out", int'(min_out), last_exp.mn);
        chk("hold_max_idx", int'(max_idx), last_exp.mxi);
        chk("hold_min_idx", int'(min_idx), last_exp.mni);
    endtask

    initial begin
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_cleared("reset");
        reset_n = 1'b1;
        @(negedge clk);

        bq = '{4'd1, 4'd10, 4'd6, 4'd15, 4'd0};
        run_burst(0, 1'b0);

        bq = '{4'd5, 4'd5, 4'd5};
        run_burst(0, 1'b0);

        bq = '{4'd3, 4'd9, 4'd2, 4'd9};
        run_burst(2, 1'b1);

        bq.delete();
        run_burst(0, 1'b0);

        bq = '{4'd7};
        run_burst(0, 1'b0);

        // Reset after two of five samples
        start = 1'b1;
        len   = CW'(5);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'd4;
        @(negedge clk);
        in_data  = 4'd11;
        @(negedge clk);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        @(negedge clk);
        check_cleared("midreset");
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midreset_no_busy", int'(busy), 0);

        bq = '{4'd8, 4'd2, 4'd12, 4'd1, 4'd12};
        run_burst(1, 1'b0);

        repeat (16) begin
            int n;
            bq.delete();
            n = $urandom_range(1, 15);
            for (int i = 0; i < n; i++) bq.push_back(DW'($urandom));
            run_burst($urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
